uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per bit period; the value SHALL be even and at least 4.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-005 parity_en  input  1  1 = even parity bit follows the data bits; 0 = 8N1.
REQ-006 rx_data  output  8  last received byte, LSB received first.
REQ-007 rx_valid  output  1  one-cycle pulse: a frame ended with a valid stop bit.
REQ-008 parity_err  output  1  parity result of the frame flagged by rx_valid; valid only while rx_valid=1.
REQ-009 frame_err  output  1  one-cycle pulse: the stop bit was sampled 0.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 rx SHALL pass through a two-flop synchronizer; both flops SHALL reset to 1; only the synchronized value (rxs) SHALL be used.
REQ-012 States SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-013 IDLE: when rxs=0, the block SHALL go to START, clear the bit-period counter, and latch parity_en for the frame.
REQ-014 START: at counter = CLKS_PER_BIT/2-1, the block SHALL sample rxs; 0 -> DATA with the counter cleared; 1 -> IDLE (false start, no output pulse).
REQ-015 DATA: at each counter = CLKS_PER_BIT-1, the block SHALL sample rxs into a shift register (LSB first), increment the bit index, and clear the counter.
REQ-016 After the 8th data sample, the block SHALL go to PARITY if the latched parity_en=1, else to STOP.
REQ-017 PARITY: at counter = CLKS_PER_BIT-1, the block SHALL sample the bit; error = XOR(8 data bits, parity bit) != 0.
REQ-018 STOP with sample = 1: rx_data SHALL load the shift register, rx_valid SHALL pulse the next cycle with parity_err (0 when parity is disabled), and the state SHALL go to IDLE.
REQ-019 STOP with sample = 0: frame_err SHALL pulse for one cycle, rx_data SHALL remain unchanged, no rx_valid SHALL be produced, and the state SHALL go to BREAK.
REQ-020 BREAK: the block SHALL remain until rxs=1, then go to IDLE; a low line SHALL NOT retrigger START while in BREAK.
REQ-021 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL wrap only by explicit clear; the bit index SHALL count 0..7.
REQ-022 Frames SHALL be accepted back-to-back: a start edge in the first cycle after returning to IDLE SHALL be detected.
REQ-023 parity_en changes mid-frame SHALL NOT affect the current frame.
REQ-024 Sampling latency: the data bit n sample SHALL occur (1.5+n)*CLKS_PER_BIT cycles, +/-1, after the first cycle with rxs=0.

Reset
REQ-025 On reset, the block SHALL enter IDLE with rx_data=8'h00, rx_valid=0, parity_err=0, frame_err=0, busy=0, counter=0, index=0, and shift register=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, the block SHALL wait in IDLE for a new falling edge.

Structure
REQ-027 Enum RX_STATE SHALL be defined in package DataTypes, and the ports SHALL use bit_t from it.
REQ-028 The FSM, counter, and shift register SHALL be implemented in uart_rx.
REQ-029 The two-flop synchronizer SHALL be a sub-module named sync_2ff.
REQ-030 Outputs SHALL be registered, and next-state logic SHALL be a single always_comb with defaults.

Verification (CLKS_PER_BIT=16)
REQ-031 Scenario 1 -- 8N1 frame, byte 0xA5 -> exactly one rx_valid, rx_data=0xA5, parity_err=0, rx_valid about 152 cycles after the start edge.
REQ-032 Scenario 2 -- rx low for 5 cycles, then high -> return to IDLE, no rx_valid, no frame_err, busy low again within 10 cycles.
REQ-033 Scenario 3 -- byte 0x3C sent with stop bit 0, line held low 40 more cycles -> one frame_err pulse, rx_data unchanged, state BREAK until the line goes high, then a following 0x55 frame received correctly.
REQ-034 Scenario 4 -- parity_en=1: byte 0x03 with parity bit 0 -> rx_valid with parity_err=0; same byte with parity bit 1 -> rx_valid with parity_err=1.
REQ-035 Scenario 5 -- reset pulsed during data bit 4 of 0xFF -> no rx_valid, all outputs at reset values; a following 0x81 frame yields rx_data=0x81.
REQ-036 Scenario 6 -- frames 0x00, 0xFF, 0x5A sent back-to-back with no idle gap -> three rx_valid pulses with matching data and no errors.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receiver: single-bit port type and the receive FSM states.
package DataTypes;

   typedef logic bit_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } RX_STATE;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both stages reset to the idle level.
module sync_2ff
   import DataTypes::*;
(
   input  bit_t clk,
   input  bit_t reset,
   input  bit_t d,
   output bit_t q
);

   bit_t meta;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional even parity, one stop bit, break detection.
// Handshake: rx_valid is a one-cycle pulse with rx_data/parity_err; there is no back-pressure.
module uart_rx
   import DataTypes::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  bit_t       clk,
   input  bit_t       reset,
   input  bit_t       rx,
   input  bit_t       parity_en,
   output logic [7:0] rx_data,
   output bit_t       rx_valid,
   output bit_t       parity_err,
   output bit_t       frame_err,
   output bit_t       busy,
   output logic [2:0] state_dbg
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   bit_t          rxs;
   RX_STATE       state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    shreg, shreg_n, rx_data_n;
   bit_t          par_lat, par_lat_n, perr, perr_n;
   bit_t          rx_valid_n, parity_err_n, frame_err_n, busy_n;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rxs)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         shreg      <= '0;
         par_lat    <= 1'b0;
         perr       <= 1'b0;
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         shreg      <= shreg_n;
         par_lat    <= par_lat_n;
         perr       <= perr_n;
         rx_data    <= rx_data_n;
         rx_valid   <= rx_valid_n;
         parity_err <= parity_err_n;
         frame_err  <= frame_err_n;
         busy       <= busy_n;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      idx_n        = idx;
      shreg_n      = shreg;
      par_lat_n    = par_lat;
      perr_n       = perr;
      rx_data_n    = rx_data;
      rx_valid_n   = 1'b0;
      parity_err_n = 1'b0;
      frame_err_n  = 1'b0;
      case (state)
         IDLE: begin
            if (!rxs) begin
               state_n   = START;
               cnt_n     = '0;
               par_lat_n = parity_en;
               perr_n    = 1'b0;
            end
         end
         START: begin
            // Re-check the line mid start bit to reject glitches.
            if (cnt == HALF) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = rxs ? IDLE : DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == FULL) begin
               cnt_n   = '0;
               shreg_n = {rxs, shreg[7:1]};
               idx_n   = idx + 3'd1;
               if (idx == 3'd7) state_n = par_lat ? PARITY : STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         PARITY: begin
            if (cnt == FULL) begin
               cnt_n   = '0;
               perr_n  = ^{shreg, rxs};
               state_n = STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            if (cnt == FULL) begin
               cnt_n = '0;
               if (rxs) begin
                  rx_data_n    = shreg;
                  rx_valid_n   = 1'b1;
                  parity_err_n = par_lat & perr;
                  state_n      = IDLE;
               end else begin
                  frame_err_n = 1'b1;
                  state_n     = BREAK;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         BREAK: begin
            if (rxs) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, hand-written corner sequences, random frames vs model.
module tb_uart_rx;
   import DataTypes::*;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic       parity_en;
   logic [7:0] rx_data;
   logic       rx_valid, parity_err, frame_err, busy;
   logic [2:0] state_dbg;

   int         checks = 0;
   int         failures = 0;
   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   time        vtime_q[$];
   logic [7:0] ferr_data_q[$];
   int         n_ferr = 0;
   int         got_rd = 0;
   int         fd_rd = 0;
   logic [7:0] last_good = 8'h00;

   typedef struct {
      logic [7:0] data;
      logic       pen;
      logic       pbit;
      logic       stopb;
      int         exp_nvalid;
      logic [7:0] exp_data;
      logic       exp_perr;
      int         exp_nferr;
   } vec_t;

   vec_t vt[8];

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .parity_en  (parity_en),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy),
      .state_dbg  (state_dbg)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // monitor: record every pulse seen on the outputs
   always @(negedge clk) begin
      if (rx_valid) begin
         got_q.push_back({parity_err, rx_data});
         vtime_q.push_back($time);
      end
      if (frame_err) begin
         n_ferr = n_ferr + 1;
         ferr_data_q.push_back(rx_data);
      end
   end

   // reference model: expected {parity_err, data} of a good frame
   function automatic logic [8:0] model(input logic [7:0] d, input logic pen, input logic pbit);
      int ones = 0;
      for (int k = 0; k < 8; k++) ones += int'(d[k]);
      ones += int'(pbit);
      return {pen && (ones % 2 == 1), d};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stopb);
      parity_en = pen;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) parity_en = ~pen;
         drive_bit(d[i]);
      end
      if (pen) drive_bit(pbit);
      drive_bit(stopb);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      @(negedge clk);
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_idle"}, int'(busy), 0);
   endtask

   // scoreboard: compare observed pulses with the expected queue
   task automatic check_frames(input string name);
      int n_got = got_q.size() - got_rd;
      int n_exp = exp_q.size();
      logic [8:0] e;
      chk({name, "_valid_count"}, n_got, n_exp);
      while (got_rd < got_q.size() && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({name, "_data"}, int'(got_q[got_rd][7:0]), int'(e[7:0]));
         chk({name, "_parity_err"}, int'(got_q[got_rd][8]), int'(e[8]));
         last_good = e[7:0];
         got_rd++;
      end
      got_rd = got_q.size();
      exp_q.delete();
      while (fd_rd < ferr_data_q.size()) begin
         chk({name, "_data_held_on_frame_err"}, int'(ferr_data_q[fd_rd]), int'(last_good));
         fd_rd++;
      end
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_rx_data"}, int'(rx_data), 0);
      chk({name, "_rx_valid"}, int'(rx_valid), 0);
      chk({name, "_parity_err"}, int'(parity_err), 0);
      chk({name, "_frame_err"}, int'(frame_err), 0);
      chk({name, "_busy"}, int'(busy), 0);
      chk({name, "_state"}, int'(state_dbg), int'(IDLE));
   endtask

   initial begin
      int   f0;
      int   lat;
      time  t0;
      logic [7:0] d;
      logic pen, pbit;
      logic [7:0] b2b[3];

      vt[0] = '{8'h03, 1'b1, 1'b0, 1'b1, 1, 8'h03, 1'b0, 0};
      vt[1] = '{8'h03, 1'b1, 1'b1, 1'b1, 1, 8'h03, 1'b1, 0};
      vt[2] = '{8'h80, 1'b1, 1'b0, 1'b1, 1, 8'h80, 1'b1, 0};
      vt[3] = '{8'h7E, 1'b1, 1'b0, 1'b1, 1, 8'h7E, 1'b0, 0};
      vt[4] = '{8'hC3, 1'b0, 1'b1, 1'b1, 1, 8'hC3, 1'b0, 0};
      vt[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1};
      vt[6] = '{8'h55, 1'b0, 1'b0, 1'b1, 1, 8'h55, 1'b0, 0};
      vt[7] = '{8'h01, 1'b1, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1};

      // reset
      reset = 1'b0;
      rx = 1'b1;
      parity_en = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("in_reset");
      #1 reset = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("after_reset");
      @(posedge clk);
      #1;

      // 8N1 0xA5 with start-to-valid latency
      exp_q.push_back({1'b0, 8'hA5});
      t0 = $time;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      wait_idle("s1", 40);
      repeat (4) @(posedge clk);
      if (vtime_q.size() > 0) begin
         lat = int'((vtime_q[vtime_q.size() - 1] - t0) / 10);
         chk("s1_latency_in_range", int'(lat >= 150 && lat <= 158), 1);
      end
      check_frames("s1");
      chk("s1_rx_data_hold", int'(rx_data), 8'hA5);

      // false start: 5 low cycles
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (5) @(posedge clk);
      #1 rx = 1'b1;
      @(negedge clk);
      chk("s2_busy_during_glitch", int'(busy), 1);
      f0 = n_ferr;
      wait_idle("s2", 10);
      repeat (20) @(posedge clk);
      check_frames("s2");
      chk("s2_no_frame_err", n_ferr - f0, 0);
      #1;

      // vector table
      for (int i = 0; i < 8; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         f0 = n_ferr;
         if (vt[i].exp_nvalid > 0) exp_q.push_back({vt[i].exp_perr, vt[i].exp_data});
         send_frame(vt[i].data, vt[i].pen, vt[i].pbit, vt[i].stopb);
         if (!vt[i].stopb) begin
            repeat (40) @(posedge clk);
            @(negedge clk);
            chk({nm, "_state_break"}, int'(state_dbg), int'(BREAK));
            chk({nm, "_busy_in_break"}, int'(busy), 1);
            @(posedge clk);
            #1 rx = 1'b1;
         end
         wait_idle(nm, 40);
         repeat (4) @(posedge clk);
         @(negedge clk);
         check_frames(nm);
         chk({nm, "_frame_err_count"}, n_ferr - f0, vt[i].exp_nferr);
         chk({nm, "_rx_data"}, int'(rx_data), int'(last_good));
         @(posedge clk);
         #1;
      end

      // reset during data bit 4 of 0xFF
      parity_en = 1'b0;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      rx = 1'b1;
      repeat (8) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("s5_in_reset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      last_good = 8'h00;
      repeat (3 * CPB) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("s5_after_reset");
      check_frames("s5_abort");
      @(posedge clk);
      #1;
      exp_q.push_back({1'b0, 8'h81});
      send_frame(8'h81, 1'b0, 1'b0, 1'b1);
      wait_idle("s5", 40);
      repeat (4) @(posedge clk);
      check_frames("s5");
      #1;

      // back-to-back frames
      b2b[0] = 8'h00;
      b2b[1] = 8'hFF;
      b2b[2] = 8'h5A;
      f0 = n_ferr;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({1'b0, b2b[i]});
         send_frame(b2b[i], 1'b0, 1'b0, 1'b1);
      end
      wait_idle("s6", 40);
      repeat (4) @(posedge clk);
      check_frames("s6");
      chk("s6_no_frame_err", n_ferr - f0, 0);
      #1;

      // random frames vs reference model
      f0 = n_ferr;
      for (int i = 0; i < 24; i++) begin
         d    = 8'($urandom_range(0, 255));
         pen  = 1'($urandom_range(0, 1));
         pbit = 1'($urandom_range(0, 1));
         exp_q.push_back(model(d, pen, pbit));
         send_frame(d, pen, pbit, 1'b1);
         rx = 1'b1;
         repeat ($urandom_range(0, 12)) @(posedge clk);
         #1;
      end
      wait_idle("rand", 40);
      repeat (4) @(posedge clk);
      check_frames("rand");
      chk("rand_no_frame_err", n_ferr - f0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
